// File: rtl/demux_sixteen_collect_if.sv
// Bit-steering bus between a serial source, the collector and the word sink.
//   Source side : in_bit, in_sel, in_valid, auto_mode -> collector; in_ready back.
//   Sink side   : out_data, out_valid, last_strobe (+ out_parity) -> sink; out_ready back.
// Modports: slave = collector view, master = source/sink (environment) view.
// Optional macro DEMUX_SIX_PARITY_EN adds out_parity.
interface demux_sixteen_collect_if #(
  parameter int unsigned N_OUT = 16,
  parameter int unsigned SEL_W = 4
);
  logic             in_bit;
  logic [SEL_W-1:0] in_sel;
  logic             in_valid;
  logic             in_ready;
  logic             auto_mode;
  logic [N_OUT-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] last_strobe;
`ifdef DEMUX_SIX_PARITY_EN
  logic             out_parity;

  modport slave (
    input  in_bit, in_sel, in_valid, auto_mode, out_ready,
    output in_ready, out_data, out_valid, last_strobe, out_parity
  );
  modport master (
    output in_bit, in_sel, in_valid, auto_mode, out_ready,
    input  in_ready, out_data, out_valid, last_strobe, out_parity
  );
`else
  modport slave (
    input  in_bit, in_sel, in_valid, auto_mode, out_ready,
    output in_ready, out_data, out_valid, last_strobe
  );
  modport master (
    output in_bit, in_sel, in_valid, auto_mode, out_ready,
    input  in_ready, out_data, out_valid, last_strobe
  );
`endif
endinterface

// File: rtl/demux_sixteen_collect.sv
// Serial-bit collector: steers in_bit into a bit of a 16-bit shadow word, either
// at in_sel (addressed mode) or at an auto-incrementing pointer (auto mode), and
// presents the completed word on a valid/ready output.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : demux_sixteen_collect_if.slave (input bit/selector handshake,
//                completed word handshake, last_strobe one-hot of last write)
// Optional macro DEMUX_SIX_PARITY_EN adds registered out_parity = ^out_data.
module demux_sixteen_collect #(
  parameter int unsigned N_OUT = 16,
  parameter int unsigned SEL_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  demux_sixteen_collect_if.slave  bus
);

  localparam logic [N_OUT-1:0] ALL_ONES = '1;
  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N_OUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             mode_q;
  logic [SEL_W-1:0] ptr_q;
  logic [N_OUT-1:0] mask_q;
  logic [N_OUT-1:0] shadow_q;
  logic [N_OUT-1:0] out_data_q;
  logic             out_valid_q;
  logic [N_OUT-1:0] last_strobe_q;

  logic             ready_c;
  logic             accept_c;
  logic             mode_eff_c;
  logic [SEL_W-1:0] idx_c;
  logic [N_OUT-1:0] onehot_c;
  logic [N_OUT-1:0] mask_nxt_c;
  logic [N_OUT-1:0] shadow_nxt_c;
  logic             complete_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = complete_c ? HOLD : FILL;
      FILL:    if (complete_c) state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / write decode; mode comes live from auto_mode only on a word's first accept
  always_comb begin
    ready_c      = 1'b0;
    accept_c     = 1'b0;
    mode_eff_c   = mode_q;
    idx_c        = '0;
    onehot_c     = '0;
    mask_nxt_c   = mask_q;
    shadow_nxt_c = shadow_q;
    complete_c   = 1'b0;

    ready_c      = (state_q != HOLD);
    accept_c     = bus.in_valid && ready_c;
    mode_eff_c   = (state_q == IDLE) ? bus.auto_mode : mode_q;
    idx_c        = mode_eff_c ? ptr_q : bus.in_sel;
    onehot_c     = N_OUT'(1) << idx_c;
    mask_nxt_c   = mask_q | onehot_c;
    shadow_nxt_c = bus.in_bit ? (shadow_q | onehot_c) : (shadow_q & ~onehot_c);
    // Rewrites leave the mask unchanged, so they never complete an addressed word
    complete_c   = accept_c && (mode_eff_c ? (ptr_q == PTR_LAST) : (mask_nxt_c == ALL_ONES));
  end

  // Shadow word, write mask, pointer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= 1'b0;
      ptr_q         <= '0;
      mask_q        <= '0;
      shadow_q      <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      last_strobe_q <= '0;
    end else begin
      if (accept_c) begin
        shadow_q      <= shadow_nxt_c;
        mask_q        <= mask_nxt_c;
        last_strobe_q <= onehot_c;
        if (mode_eff_c)        ptr_q  <= ptr_q + SEL_W'(1);
        if (state_q == IDLE)   mode_q <= bus.auto_mode;
      end
      if (complete_c) begin
        out_data_q  <= shadow_nxt_c;
        out_valid_q <= 1'b1;
      end
      if ((state_q == HOLD) && bus.out_ready) begin
        out_valid_q <= 1'b0;
        mask_q      <= '0;
        ptr_q       <= '0;
      end
    end
  end

`ifdef DEMUX_SIX_PARITY_EN
  logic out_parity_q;

  // Parity captured alongside the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          out_parity_q <= 1'b0;
    else if (complete_c) out_parity_q <= ^shadow_nxt_c;
  end

  assign bus.out_parity = out_parity_q;
`endif

  assign bus.in_ready    = ready_c;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.last_strobe = last_strobe_q;

endmodule

// File: tb/tb_demux_sixteen_collect.sv
// Self-checking bench for demux_sixteen_collect: table-driven words, directed
// multi-cycle corner sequences, then randomized traffic against a word-level model.
module tb_demux_sixteen_collect;

  localparam int unsigned N_OUT = 16;
  localparam int unsigned SEL_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux_sixteen_collect_if #(.N_OUT(N_OUT), .SEL_W(SEL_W)) bus ();

  demux_sixteen_collect #(.N_OUT(N_OUT), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.in_sel    = '0;
    bus.auto_mode = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic acc(input logic b, input logic [3:0] s, input logic m);
    bus.in_valid  = 1'b1;
    bus.in_bit    = b;
    bus.in_sel    = s;
    bus.auto_mode = m;
    cyc();
    bus.in_valid  = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // Word-level reference model
  logic        m_hold;
  logic [15:0] m_word, m_out, m_strobe;
  bit          m_written[16];
  int          m_count, m_pos;
  logic        m_mode, m_started;

  task automatic m_reset();
    m_hold = 1'b0; m_word = '0; m_out = '0; m_strobe = '0;
    for (int i = 0; i < 16; i++) m_written[i] = 1'b0;
    m_count = 0; m_pos = 0; m_mode = 1'b0; m_started = 1'b0;
  endtask

  task automatic m_step(input logic v, input logic b, input logic [3:0] s,
                        input logic am, input logic ordy);
    int idx;
    if (m_hold) begin
      if (ordy) begin
        m_hold = 1'b0;
        for (int i = 0; i < 16; i++) m_written[i] = 1'b0;
        m_count = 0;
        m_pos   = 0;
      end
    end else if (v) begin
      if (!m_started) begin
        m_mode    = am;
        m_started = 1'b1;
      end
      idx = m_mode ? m_pos : int'(s);
      m_word[idx] = b;
      m_strobe = '0;
      m_strobe[idx] = 1'b1;
      if (!m_written[idx]) begin
        m_written[idx] = 1'b1;
        m_count++;
      end
      if (m_mode) m_pos++;
      if (m_mode ? (m_pos == 16) : (m_count == 16)) begin
        m_out     = m_word;
        m_hold    = 1'b1;
        m_started = 1'b0;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic        auto_m;
    logic        descend;
    logic [15:0] word;
    logic [15:0] exp_strobe;
    logic        exp_par;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [3:0] s;
    logic       m;

    vecs[0] = '{"auto_0001", 1'b1, 1'b0, 16'h0001, 16'h8000, 1'b1};
    vecs[1] = '{"addr_desc_0400", 1'b0, 1'b1, 16'h0400, 16'h0001, 1'b1};
    vecs[2] = '{"auto_8001", 1'b1, 1'b0, 16'h8001, 16'h8000, 1'b0};
    vecs[3] = '{"addr_asc_8003", 1'b0, 1'b0, 16'h8003, 16'h8000, 1'b1};

    rst_n = 1'b0;
    idle_inputs();
    cyc();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_last_strobe", 32'(bus.last_strobe), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef DEMUX_SIX_PARITY_EN
    check("rst_out_parity", 32'(bus.out_parity), 32'd0);
`endif
    cyc();
    rst_n = 1'b1;
    cyc();

    // Table-driven full words; auto_mode is randomized after the first accept
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 16; i++) begin
        if (vecs[v].auto_m) s = 4'($urandom);
        else                s = vecs[v].descend ? 4'(15 - i) : 4'(i);
        m = (i == 0) ? vecs[v].auto_m : 1'($urandom);
        acc(vecs[v].word[vecs[v].auto_m ? 4'(i) : s], s, m);
        if (i == 14) check({vecs[v].name, "_no_early_valid"}, 32'(bus.out_valid), 32'd0);
      end
      check({vecs[v].name, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({vecs[v].name, "_data"}, 32'(bus.out_data), 32'(vecs[v].word));
      check({vecs[v].name, "_strobe"}, 32'(bus.last_strobe), 32'(vecs[v].exp_strobe));
      check({vecs[v].name, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
`ifdef DEMUX_SIX_PARITY_EN
      check({vecs[v].name, "_parity"}, 32'(bus.out_parity), 32'(vecs[v].exp_par));
`endif
      drain();
      check({vecs[v].name, "_drained_valid"}, 32'(bus.out_valid), 32'd0);
      check({vecs[v].name, "_drained_ready"}, 32'(bus.in_ready), 32'd1);
      check({vecs[v].name, "_data_retained"}, 32'(bus.out_data), 32'(vecs[v].word));
    end

    // Addressed rewrite of index 3 does not count toward completion
    acc(1'b1, 4'd3, 1'b0);
    acc(1'b0, 4'd3, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 3) continue;
      if (i == 15) check("rewrite_not_complete_at_16", 32'(bus.out_valid), 32'd0);
      acc(1'b1, 4'(i), 1'b0);
    end
    check("rewrite_valid", 32'(bus.out_valid), 32'd1);
    check("rewrite_data", 32'(bus.out_data), 32'h0000_FFF7);
    drain();

    // Backpressure: word held while in_valid stays asserted
    for (int i = 0; i < 16; i++) begin
      s = 4'(i);
      acc(1'(16'h1234 >> s), 4'($urandom), 1'b1);
    end
    bus.in_valid = 1'b1; bus.in_bit = 1'b1; bus.in_sel = 4'd9; bus.auto_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_data", 32'(bus.out_data), 32'h1234);
      check("bp_strobe_unchanged", 32'(bus.last_strobe), 32'h8000);
    end
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    check("bp_no_accept_on_handshake", 32'(bus.last_strobe), 32'h8000);
    cyc();
    bus.in_valid = 1'b0;
    check("bp_first_accept_after_idle", 32'(bus.last_strobe), 32'h0001);

    // Reset mid-word: 7 auto accepts total, then an async pulse between edges
    for (int i = 0; i < 6; i++) acc(1'b1, 4'd0, 1'b1);
    check("pre_reset_strobe", 32'(bus.last_strobe), 32'h0040);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_last_strobe", 32'(bus.last_strobe), 32'h0);
    check("midrst_out_data", 32'(bus.out_data), 32'h0);
    #1 rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 16; i++) begin
      s = 4'(i);
      acc(1'(16'h00A5 >> s), 4'($urandom), 1'b1);
    end
    check("postrst_valid", 32'(bus.out_valid), 32'd1);
    check("postrst_data", 32'(bus.out_data), 32'h00A5);
    check("postrst_strobe", 32'(bus.last_strobe), 32'h8000);
    drain();

    // Randomized traffic against the reference model
    do_reset();
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_bit    = 1'($urandom);
      bus.in_sel    = 4'($urandom);
      bus.auto_mode = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 2) == 0);
      m_step(bus.in_valid, bus.in_bit, bus.in_sel, bus.auto_mode, bus.out_ready);
      cyc();
      check("rnd_out_valid", 32'(bus.out_valid), 32'(m_hold));
      check("rnd_out_data", 32'(bus.out_data), 32'(m_out));
      check("rnd_last_strobe", 32'(bus.last_strobe), 32'(m_strobe));
      check("rnd_in_ready", 32'(bus.in_ready), 32'(!m_hold));
`ifdef DEMUX_SIX_PARITY_EN
      check("rnd_out_parity", 32'(bus.out_parity), 32'(^m_out));
`endif
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
